bus8_autoclear_timed: RTL and testbench

//  Next-generation Bus8 autoclear register block. NUM_CH channels that software starts/stops via Bus8

---
 rtl/bus8_autoclear_timed.sv | 170 +++++++++++++++++
 tb/tb_bus8_autoclear_timed.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus8_autoclear_timed.sv
// Bus8 autoclear register block: software starts/stops NUM_CH engine channels, which clear
// themselves on a done edge or a programmable timeout, with sticky timeout status and an IRQ.
module bus8_autoclear_timed #(
   parameter int          NUM_CH    = 2,
   parameter int          PULSE_LEN = 4,
   parameter logic [15:0] LIMIT_RST = 16'h0
) (
   input  logic              i_Bus_Clk,
   input  logic              i_Bus_Rst,
   input  logic              i_Bus_CS,
   input  logic              i_Bus_Wr_Rd_n,
   input  logic [3:0]        i_Bus_Addr8,
   input  logic [7:0]        i_Bus_Wr_Data,
   output logic [7:0]        o_Bus_Rd_Data,
   output logic              o_Bus_Rd_DV,
   output logic [NUM_CH-1:0] o_AC_Busy,
   output logic [NUM_CH-1:0] o_AC_Start_Pulse,
   output logic [NUM_CH-1:0] o_AC_Abort,
   input  logic [NUM_CH-1:0] i_AC_Done,
   output logic              o_Irq
);

   typedef enum logic [3:0] {
      ADDR_START     = 4'h0,
      ADDR_STATE     = 4'h1,
      ADDR_STOP      = 4'h2,
      ADDR_HIST      = 4'h3,
      ADDR_HIST_CLR  = 4'h4,
      ADDR_TO_STATUS = 4'h5,
      ADDR_TO_CLR    = 4'h6,
      ADDR_LIMIT_LO  = 4'h7,
      ADDR_LIMIT_HI  = 4'h8,
      ADDR_IRQ_EN    = 4'h9
   } addr_e;

   logic              wr_acc;
   logic              rd_acc;
   logic [NUM_CH-1:0] wr_mask;
   logic [NUM_CH-1:0] start_stb;
   logic [NUM_CH-1:0] stop_stb;
   logic [NUM_CH-1:0] hist_clr_stb;
   logic [NUM_CH-1:0] to_clr_stb;
   logic [NUM_CH-1:0] hist;
   logic [NUM_CH-1:0] to_status;
   logic [NUM_CH-1:0] irq_en;
   logic [NUM_CH-1:0] done_q;
   logic [NUM_CH-1:0] done_edge;
   logic [NUM_CH-1:0] timeout_hit;
   logic [NUM_CH-1:0] to_set;
   logic [15:0]       limit;
   logic [7:0]        limit_shadow;
   logic [15:0]       run_cnt   [NUM_CH];
   logic [7:0]        pulse_cnt [NUM_CH];
   logic [7:0]        rd_mux;

   assign wr_acc    = i_Bus_CS & i_Bus_Wr_Rd_n;
   assign rd_acc    = i_Bus_CS & ~i_Bus_Wr_Rd_n;
   assign wr_mask   = i_Bus_Wr_Data[NUM_CH-1:0];
   assign done_edge = i_AC_Done & ~done_q;

   always_comb begin
      rd_mux = '0;
      case (i_Bus_Addr8)
         ADDR_STATE:     rd_mux[NUM_CH-1:0] = o_AC_Busy;
         ADDR_HIST:      rd_mux[NUM_CH-1:0] = hist;
         ADDR_TO_STATUS: rd_mux[NUM_CH-1:0] = to_status;
         ADDR_LIMIT_LO:  rd_mux = limit[7:0];
         ADDR_LIMIT_HI:  rd_mux = limit[15:8];
         ADDR_IRQ_EN:    rd_mux[NUM_CH-1:0] = irq_en;
         default:        rd_mux = '0;
      endcase
   end

   // Compare against count+1 so a limit lowered below a running count still fires next clock.
   always_comb begin
      timeout_hit = '0;
      to_set      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         timeout_hit[i] = (limit != 16'h0) &&
                          (({1'b0, run_cnt[i]} + 17'd1) >= {1'b0, limit});
         to_set[i]      = o_AC_Busy[i] & ~start_stb[i] & ~stop_stb[i] &
                          ~done_edge[i] & timeout_hit[i];
      end
   end

   always_ff @(posedge i_Bus_Clk) begin
      if (i_Bus_Rst) begin
         start_stb     <= '0;
         stop_stb      <= '0;
         hist_clr_stb  <= '0;
         to_clr_stb    <= '0;
         irq_en        <= '0;
         limit         <= LIMIT_RST;
         limit_shadow  <= '0;
         o_Bus_Rd_Data <= '0;
         o_Bus_Rd_DV   <= 1'b0;
      end else begin
         start_stb     <= '0;
         stop_stb      <= '0;
         hist_clr_stb  <= '0;
         to_clr_stb    <= '0;
         o_Bus_Rd_DV   <= rd_acc;
         o_Bus_Rd_Data <= rd_acc ? rd_mux : 8'h00;
         if (wr_acc) begin
            case (i_Bus_Addr8)
               ADDR_START:    start_stb    <= wr_mask;
               ADDR_STOP:     stop_stb     <= wr_mask;
               ADDR_HIST_CLR: hist_clr_stb <= wr_mask;
               ADDR_TO_CLR:   to_clr_stb   <= wr_mask;
               ADDR_LIMIT_LO: limit_shadow <= i_Bus_Wr_Data;
               ADDR_LIMIT_HI: limit        <= {i_Bus_Wr_Data, limit_shadow};
               ADDR_IRQ_EN:   irq_en       <= wr_mask;
               default:       ;
            endcase
         end
      end
   end

   // Per-channel run state; branch order encodes start > stop > done edge > timeout.
   always_ff @(posedge i_Bus_Clk) begin
      if (i_Bus_Rst) begin
         o_AC_Busy  <= '0;
         o_AC_Abort <= '0;
         o_Irq      <= 1'b0;
         hist       <= '0;
         to_status  <= '0;
         done_q     <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            run_cnt[i]   <= '0;
            pulse_cnt[i] <= '0;
         end
      end else begin
         done_q    <= i_AC_Done;
         hist      <= (hist & ~hist_clr_stb) | start_stb;
         to_status <= (to_status & ~to_clr_stb) | to_set;
         o_Irq     <= |(to_status & irq_en);
         for (int i = 0; i < NUM_CH; i++) begin
            o_AC_Abort[i] <= 1'b0;
            if (pulse_cnt[i] != 8'd0) begin
               pulse_cnt[i] <= pulse_cnt[i] - 8'd1;
            end
            if (start_stb[i]) begin
               o_AC_Busy[i] <= 1'b1;
               run_cnt[i]   <= '0;
               pulse_cnt[i] <= 8'(PULSE_LEN);
            end else if (o_AC_Busy[i]) begin
               if (stop_stb[i]) begin
                  o_AC_Busy[i]  <= 1'b0;
                  o_AC_Abort[i] <= 1'b1;
               end else if (done_edge[i]) begin
                  o_AC_Busy[i] <= 1'b0;
               end else if (timeout_hit[i]) begin
                  o_AC_Busy[i]  <= 1'b0;
                  o_AC_Abort[i] <= 1'b1;
               end else if (run_cnt[i] != 16'hFFFF) begin
                  run_cnt[i] <= run_cnt[i] + 16'd1;
               end
            end
         end
      end
   end

   always_comb begin
      o_AC_Start_Pulse = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         o_AC_Start_Pulse[i] = (pulse_cnt[i] != 8'd0);
      end
   end

endmodule

// File: tb/tb_bus8_autoclear_timed.sv
// Randomized + directed bench for bus8_autoclear_timed; a cycle-counting reference model
// predicts every output, and read data is scoreboarded through a queue.
module tb_bus8_autoclear_timed;

   localparam int          NCH  = 2;
   localparam int          PLEN = 4;
   localparam logic [15:0] LRST = 16'h0000;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cs = 1'b0;
   logic           wr_rd_n = 1'b0;
   logic [3:0]     addr = '0;
   logic [7:0]     wr_data = '0;
   logic [7:0]     rd_data;
   logic           rd_dv;
   logic [NCH-1:0] busy;
   logic [NCH-1:0] start_pulse;
   logic [NCH-1:0] abort;
   logic [NCH-1:0] done = '0;
   logic           irq;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b1;

   // Reference model state (values as seen just after the most recent clock edge)
   longint         cyc = 0;
   logic [NCH-1:0] m_busy = '0, m_abort = '0, m_hist = '0, m_to = '0, m_en = '0;
   logic [NCH-1:0] p_start = '0, p_stop = '0, p_hclr = '0, p_tclr = '0, m_done_prev = '0;
   logic           m_irq = 1'b0, m_dv = 1'b0;
   logic [15:0]    m_limit = LRST;
   logic [7:0]     m_shadow = '0;
   longint         m_on [NCH];
   longint         m_start_cyc [NCH];
   bit             m_started [NCH];
   logic [7:0]     rd_q [$];

   bus8_autoclear_timed #(.NUM_CH(NCH), .PULSE_LEN(PLEN), .LIMIT_RST(LRST)) dut (
      .i_Bus_Clk(clk), .i_Bus_Rst(rst), .i_Bus_CS(cs), .i_Bus_Wr_Rd_n(wr_rd_n),
      .i_Bus_Addr8(addr), .i_Bus_Wr_Data(wr_data), .o_Bus_Rd_Data(rd_data),
      .o_Bus_Rd_DV(rd_dv), .o_AC_Busy(busy), .o_AC_Start_Pulse(start_pulse),
      .o_AC_Abort(abort), .i_AC_Done(done), .o_Irq(irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [3:0] a);
      logic [7:0] r;
      r = '0;
      case (a)
         4'h1: r[NCH-1:0] = m_busy;
         4'h3: r[NCH-1:0] = m_hist;
         4'h5: r[NCH-1:0] = m_to;
         4'h7: r = m_limit[7:0];
         4'h8: r = m_limit[15:8];
         4'h9: r[NCH-1:0] = m_en;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Model: a channel stays up for at most 'limit' whole clocks after its start takes effect.
   always @(posedge clk) begin
      logic [7:0]     rd_val;
      logic [NCH-1:0] dedge, to_set;
      logic           irq_next;
      if (rst) begin
         m_busy = '0; m_abort = '0; m_hist = '0; m_to = '0; m_en = '0; m_irq = 1'b0;
         p_start = '0; p_stop = '0; p_hclr = '0; p_tclr = '0; m_done_prev = '0;
         m_limit = LRST; m_shadow = '0; m_dv = 1'b0;
         for (int i = 0; i < NCH; i++) m_started[i] = 1'b0;
      end else begin
         cyc++;
         rd_val      = model_read(addr);
         irq_next    = |(m_to & m_en);
         dedge       = done & ~m_done_prev;
         m_done_prev = done;
         to_set      = '0;
         for (int i = 0; i < NCH; i++) begin
            m_abort[i] = 1'b0;
            if (p_start[i]) begin
               m_busy[i] = 1'b1; m_on[i] = 0; m_started[i] = 1'b1; m_start_cyc[i] = cyc;
            end else if (m_busy[i]) begin
               if (p_stop[i]) begin
                  m_busy[i] = 1'b0; m_abort[i] = 1'b1;
               end else if (dedge[i]) begin
                  m_busy[i] = 1'b0;
               end else begin
                  m_on[i]++;
                  if (m_limit != 16'h0 && m_on[i] >= longint'(m_limit)) begin
                     m_busy[i] = 1'b0; m_abort[i] = 1'b1; to_set[i] = 1'b1;
                  end
               end
            end
         end
         m_hist = (m_hist & ~p_hclr) | p_start;
         m_to   = (m_to & ~p_tclr) | to_set;
         m_irq  = irq_next;
         p_start = '0; p_stop = '0; p_hclr = '0; p_tclr = '0;
         m_dv = cs & ~wr_rd_n;
         if (m_dv) rd_q.push_back(rd_val);
         if (cs & wr_rd_n) begin
            case (addr)
               4'h0: p_start  = wr_data[NCH-1:0];
               4'h2: p_stop   = wr_data[NCH-1:0];
               4'h4: p_hclr   = wr_data[NCH-1:0];
               4'h6: p_tclr   = wr_data[NCH-1:0];
               4'h7: m_shadow = wr_data;
               4'h8: m_limit  = {wr_data, m_shadow};
               4'h9: m_en     = wr_data[NCH-1:0];
               default: ;
            endcase
         end
      end
   end

   // Monitor: per-cycle output comparison plus scoreboard pop on every read-valid
   always @(negedge clk) begin
      logic [NCH-1:0] exp_pulse;
      logic [7:0]     exp_rd;
      for (int i = 0; i < NCH; i++)
         exp_pulse[i] = m_started[i] && ((cyc - m_start_cyc[i]) < PLEN);
      if (chk_en) begin
         checkOutput("busy", 32'(busy), 32'(m_busy));
         checkOutput("start_pulse", 32'(start_pulse), 32'(exp_pulse));
         checkOutput("abort", 32'(abort), 32'(m_abort));
         checkOutput("irq", 32'(irq), 32'(m_irq));
         checkOutput("rd_dv", 32'(rd_dv), 32'(m_dv));
      end
      if (rd_dv === 1'b1) begin
         if (rd_q.size() == 0) begin
            checkOutput("rd_unexpected", 32'(rd_data), 32'h100);
         end else begin
            exp_rd = rd_q.pop_front();
            checkOutput("rd_data", 32'(rd_data), 32'(exp_rd));
         end
      end
   end

   task automatic applyStimulus(input logic wr, input logic [3:0] a, input logic [7:0] d);
      cs = 1'b1; wr_rd_n = wr; addr = a; wr_data = d;
      @(negedge clk);
      cs = 1'b0; wr_rd_n = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [3:0] ra;
      logic [7:0] rd;
      int         di;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_irq", 32'(irq), 32'h0);
      rst = 1'b0;

      // T1: simple start of channel 0
      applyStimulus(1'b1, 4'h0, 8'h01);
      idle(1);
      checkOutput("t1_busy", 32'(busy), 32'h1);
      checkOutput("t1_pulse", 32'(start_pulse), 32'h1);
      idle(4);
      applyStimulus(1'b0, 4'h1, 8'h00);
      applyStimulus(1'b0, 4'h3, 8'h00);
      applyStimulus(1'b1, 4'h2, 8'h01);
      idle(3);

      // T2: timeout of channel 1 with interrupt
      applyStimulus(1'b1, 4'h7, 8'h10);
      applyStimulus(1'b1, 4'h8, 8'h00);
      applyStimulus(1'b1, 4'h9, 8'h02);
      applyStimulus(1'b1, 4'h0, 8'h02);
      idle(25);
      checkOutput("t2_irq_set", 32'(irq), 32'h1);
      applyStimulus(1'b0, 4'h5, 8'h00);
      applyStimulus(1'b1, 4'h6, 8'h02);
      idle(2);
      checkOutput("t2_irq_clr", 32'(irq), 32'h0);

      // T3: done level held across start, then a real edge
      done[0] = 1'b1;
      applyStimulus(1'b1, 4'h0, 8'h01);
      idle(5);
      checkOutput("t3_held_done", 32'(busy[0]), 32'h1);
      done[0] = 1'b0;
      idle(2);
      done[0] = 1'b1;
      idle(2);
      applyStimulus(1'b0, 4'h1, 8'h00);
      applyStimulus(1'b0, 4'h3, 8'h00);

      // T4: restart vs done edge, TO_CLR vs timeout on the same edge
      done[0] = 1'b0;
      applyStimulus(1'b1, 4'h4, 8'h03);
      applyStimulus(1'b1, 4'h0, 8'h01);
      idle(2);
      applyStimulus(1'b1, 4'h0, 8'h03);
      done[0] = 1'b1;
      idle(1);
      idle(13);
      applyStimulus(1'b1, 4'h6, 8'h03);
      idle(2);
      applyStimulus(1'b0, 4'h5, 8'h00);
      applyStimulus(1'b0, 4'h3, 8'h00);

      // T5: shadow-only write, then unlimited run past counter saturation
      done = '0;
      applyStimulus(1'b1, 4'h7, 8'h55);
      applyStimulus(1'b0, 4'h7, 8'h00);
      applyStimulus(1'b0, 4'h8, 8'h00);
      applyStimulus(1'b1, 4'h7, 8'h00);
      applyStimulus(1'b1, 4'h8, 8'h00);
      applyStimulus(1'b1, 4'h0, 8'h01);
      chk_en = 1'b0;
      idle(66000);
      chk_en = 1'b1;
      idle(1);
      checkOutput("t5_still_busy", 32'(busy[0]), 32'h1);
      applyStimulus(1'b0, 4'h5, 8'h00);
      applyStimulus(1'b1, 4'h2, 8'h01);
      idle(3);

      // T6: reset in the middle of a start pulse
      applyStimulus(1'b1, 4'h7, 8'h20);
      applyStimulus(1'b1, 4'h8, 8'h00);
      applyStimulus(1'b1, 4'h0, 8'h03);
      idle(1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6_busy", 32'(busy), 32'h0);
      checkOutput("t6_pulse", 32'(start_pulse), 32'h0);
      rst = 1'b0;
      applyStimulus(1'b0, 4'h7, 8'h00);
      applyStimulus(1'b0, 4'h8, 8'h00);

      // Randomized traffic
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            di = int'($urandom_range(0, NCH - 1));
            done[di] = ~done[di];
         end
         if ($urandom_range(0, 9) < 6) begin
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom);
            if (ra == 4'h8) rd = 8'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), ra, rd);
         end else begin
            idle(1);
         end
      end
      idle(5);
      checkOutput("rdq_empty", 32'(rd_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
